// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants: flag indices, stage-state encoding, entry width
package alu_pkg;

  // Bit positions of the flags inside the 4-bit {Z,N,C,V} field
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAG_BITS = 4;

  // Occupancy of the 2-entry result skid buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // A stored entry is the result followed by its flags
  function automatic int entry_width(input int width);
    return width + FLAG_BITS;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - valid/ready result bus into and out of the ALU result stage
interface alu_result_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;

  // Producer of ALU results and consumer of the stage output
  modport master (
    output in_valid, in_result, in_carry, in_ovf, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  // The result stage itself
  modport slave (
    input  in_valid, in_result, in_carry, in_ovf, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational Z/N/C/V derivation from result, carry and overflow
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             ovf,
  output logic [3:0]       flags
);

  // Zero and sign come from the result, carry and overflow pass straight through
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result/flag stage with 2-entry skid buffer (optional ALU_STICKY_OVF_EN)
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus,
  input  logic                clr_sticky,
  output logic                sticky_v
);

  localparam int EW = entry_width(WIDTH);

  stage_state_t   state;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [EW-1:0]  main_q;
  logic [EW-1:0]  skid_q;
  logic [3:0]     in_flags;
  logic [EW-1:0]  in_entry;
  logic           in_fire;
  logic           out_fire;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result (bus.in_result),
    .carry  (bus.in_carry),
    .ovf    (bus.in_ovf),
    .flags  (in_flags)
  );

  assign in_entry = {bus.in_result, in_flags};
  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = main_q[EW-1:FLAG_BITS];
  assign bus.out_flags  = main_q[FLAG_BITS-1:0];

  // Skid FSM: in_ready is a flop so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            main_q      <= in_entry;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid_q     <= in_entry;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end else if (in_fire && out_fire) begin
            main_q <= in_entry;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q;

  // Sticky overflow: an overflowing entry leaving the stage beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (out_fire && main_q[FLAG_V]) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_v = sticky_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = clr_sticky;
  assign sticky_v          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed and randomized checks of alu_result_stage
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_sticky;
  logic sticky_v;

  alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_result_stage #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .sticky_v   (sticky_v)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] r, input logic c, input logic o);
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_carry  = c;
    bus.in_ovf    = o;
  endtask

  function automatic logic [11:0] model(input logic [7:0] r, input logic c, input logic o);
    return {r, (r == 8'h00), r[7], c, o};
  endfunction

  logic [11:0] q[$];
  logic [11:0] exp_e;
  logic        pend;
  logic        rdy_before;

  initial begin
    rst_n         = 1'b1;
    clr_sticky    = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_flags", bus.out_flags, 0);
    check("rst_sticky", sticky_v, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);

    // fill then reset mid-stream
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("prefill_full", bus.in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_result", bus.out_result, 0);
    check("mid_rst_out_flags", bus.out_flags, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    #3 rst_n = 1'b1;
    tick();
    check("mid_rst_release_ready", bus.in_ready, 1);
    check("mid_rst_skid_gone", bus.out_valid, 0);

    // single pass
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("single_valid", bus.out_valid, 1);
    check("single_result", bus.out_result, 8'h00);
    check("single_flags", bus.out_flags, 4'b1010);
    tick();
    check("single_drained", bus.out_valid, 0);

    // back-pressure fill
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h80, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h7F, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_result0", bus.out_result, 8'h80);
    check("bp_flags0", bus.out_flags, 4'b0100);
    tick();
    check("bp_hold_result", bus.out_result, 8'h80);
    bus.out_ready = 1'b1;
    tick();
    check("bp_in_ready_back", bus.in_ready, 1);
    check("bp_result1", bus.out_result, 8'h7F);
    check("bp_flags1", bus.out_flags, 4'b0000);
    tick();
    check("bp_drained", bus.out_valid, 0);

    // streaming
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      tick();
      check("stream_in_ready", bus.in_ready, 1);
      check("stream_valid", bus.out_valid, 1);
      check("stream_result", bus.out_result, 32'(i));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("stream_drained", bus.out_valid, 0);

    // simultaneous in/out while ONE
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    check("simul_first", bus.out_result, 8'hAA);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    check("simul_valid", bus.out_valid, 1);
    check("simul_result", bus.out_result, 8'h55);
    check("simul_not_full", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    tick();
    check("simul_no_extra", bus.out_valid, 0);

    // random toggling against a scoreboard
    pend = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rdy_before = bus.in_ready;
      if (!pend) begin
        if ($urandom_range(0, 3) != 0)
          drive(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else
          drive(1'b0, 8'h00, 1'b0, 1'b0);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rand_in_ready_stable", bus.in_ready, rdy_before);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("rand_underflow", bus.out_valid, 0);
        end else begin
          exp_e = q.pop_front();
          check("rand_out", {bus.out_result, bus.out_flags}, exp_e);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_result, bus.in_carry, bus.in_ovf));
        pend = 1'b0;
      end else begin
        pend = bus.in_valid;
      end
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("drain_underflow", bus.out_valid, 0);
        end else begin
          exp_e = q.pop_front();
          check("drain_out", {bus.out_result, bus.out_flags}, exp_e);
        end
      end
      tick();
    end
    check("drain_left", q.size(), 0);
    check("drain_valid", bus.out_valid, 0);

`ifdef ALU_STICKY_OVF_EN
    // sticky overflow
    bus.out_ready = 1'b1;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("sticky_cleared_init", sticky_v, 0);
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    tick();
    check("sticky_set", sticky_v, 1);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check("sticky_persist", sticky_v, 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("sticky_clr_alone", sticky_v, 0);
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h04, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("sticky_not_yet", sticky_v, 0);
    bus.out_ready = 1'b1;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    bus.out_ready = 1'b0;
    check("sticky_set_wins", sticky_v, 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("sticky_clr_final", sticky_v, 0);
`else
    // sticky absent
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check("sticky_absent", sticky_v, 0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("sticky_absent_clr", sticky_v, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
